// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch sequencing controller: FSM state
// encodings, BCD digit limits and the terminal-count helper.
package stopwatch_pkg;

  // Width of one BCD digit of the external loop counter.
  localparam int DIGIT_W = 4;

  // Largest legal value of each BCD digit; together they form count 99.
  localparam logic [DIGIT_W-1:0] BCD_MAX_TENS = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_MAX_ONES = 4'd9;

  // Controller states; the encoding is visible on the debug state port.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_LAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // True only for an exact 9/9 digit pair. Non-BCD nibbles never match.
  function automatic logic is_terminal(input logic [DIGIT_W-1:0] tens,
                                       input logic [DIGIT_W-1:0] ones);
    return (tens == BCD_MAX_TENS) && (ones == BCD_MAX_ONES);
  endfunction

endpackage

// File: rtl/stopwatch_tick_gen.sv
// Prescaler for the stopwatch: counts 0..TICK_DIV-1 while run is high,
// holds its value while run is low, and can be restarted from zero.
module stopwatch_tick_gen #(
  parameter int TICK_DIV = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int               CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_last;

  assign w_at_last = (r_cnt == LAST);

  // Prescaler register: restart wins, otherwise advance and wrap while running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (restart) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= w_at_last ? '0 : (r_cnt + ONE);
    end
  end

  // Tick is only meaningful while running; a frozen prescaler never ticks.
  assign tick = run && w_at_last;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller. Turns start/stop and lap/reset button
// pulses into increment/clear strobes for an external two-digit BCD counter,
// stops (or wraps) at 99, and drives a display that can be frozen on a lap.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 50,
  parameter bit WRAP     = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_ss,
  input  logic               btn_lr,
  input  logic [DIGIT_W-1:0] cnt1,
  input  logic [DIGIT_W-1:0] cnt0,
  output logic               cnt_en,
  output logic               cnt_clr,
  output logic [DIGIT_W-1:0] disp1,
  output logic [DIGIT_W-1:0] disp0,
  output logic               running,
  output logic               done,
  output logic [2:0]         state
);

  state_t             r_state;
  state_t             w_state_nxt;

  logic               w_run;
  logic               w_restart;
  logic               w_tick;
  logic               w_terminal;
  logic               w_stop_at_max;
  logic               w_capture;
  logic               w_clr_req;
  logic               w_show_lap;

  logic [DIGIT_W-1:0] r_lap1;
  logic [DIGIT_W-1:0] r_lap0;
  logic [DIGIT_W-1:0] w_lap1_nxt;
  logic [DIGIT_W-1:0] w_lap0_nxt;

  logic               r_cnt_en;
  logic               r_cnt_clr;
  logic [DIGIT_W-1:0] r_disp1;
  logic [DIGIT_W-1:0] r_disp0;

  // The prescaler runs in RUN and LAP, restarts only on a fresh start from IDLE.
  assign w_run     = (r_state == ST_RUN) || (r_state == ST_LAP);
  assign w_restart = (r_state == ST_IDLE) && btn_ss;

  stopwatch_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .run     (w_run),
    .restart (w_restart),
    .tick    (w_tick)
  );

  // A tick at 99 either stops the watch (no increment) or lets it wrap.
  assign w_terminal    = is_terminal(cnt1, cnt0);
  assign w_stop_at_max = w_tick && w_terminal && (WRAP == 1'b0);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: btn_ss outranks btn_lr, buttons outrank terminal count.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (btn_ss) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (btn_ss) begin
          w_state_nxt = ST_PAUSE;
        end else if (btn_lr) begin
          w_state_nxt = ST_LAP;
        end else if (w_stop_at_max) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_LAP: begin
        if (btn_ss) begin
          w_state_nxt = ST_PAUSE;
        end else if (btn_lr) begin
          w_state_nxt = ST_RUN;
        end else if (w_stop_at_max) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_PAUSE: begin
        if (btn_ss) begin
          w_state_nxt = ST_RUN;
        end else if (btn_lr) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (btn_lr) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Every accepted btn_lr that lands in IDLE (from IDLE, PAUSE or DONE) clears
  // the counter. RUN/LAP never go to IDLE, so this never overlaps cnt_en.
  assign w_clr_req = btn_lr && (w_state_nxt == ST_IDLE);

  // Lap is captured on the RUN->LAP edge only.
  assign w_capture  = (r_state == ST_RUN) && (w_state_nxt == ST_LAP);
  assign w_lap1_nxt = w_capture ? cnt1 : r_lap1;
  assign w_lap0_nxt = w_capture ? cnt0 : r_lap0;
  assign w_show_lap = (w_state_nxt == ST_LAP);

  // Lap registers and registered strobes/display driven to the counter and digits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lap1    <= '0;
      r_lap0    <= '0;
      r_cnt_en  <= 1'b0;
      r_cnt_clr <= 1'b0;
      r_disp1   <= '0;
      r_disp0   <= '0;
    end else begin
      r_lap1    <= w_lap1_nxt;
      r_lap0    <= w_lap0_nxt;
      r_cnt_en  <= w_tick && !w_stop_at_max;
      r_cnt_clr <= w_clr_req;
      r_disp1   <= w_show_lap ? w_lap1_nxt : cnt1;
      r_disp0   <= w_show_lap ? w_lap0_nxt : cnt0;
    end
  end

  // State-decoded status outputs.
  always_comb begin
    running = 1'b0;
    done    = 1'b0;
    unique case (r_state)
      ST_RUN, ST_LAP: running = 1'b1;
      ST_DONE:        done    = 1'b1;
      default: begin
        running = 1'b0;
        done    = 1'b0;
      end
    endcase
  end

  assign state   = r_state;
  assign cnt_en  = r_cnt_en;
  assign cnt_clr = r_cnt_clr;
  assign disp1   = r_disp1;
  assign disp0   = r_disp0;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Sequencing controller for the two-digit BCD loop counter (tens/ones nibbles, 00..99).
- Turns two single-cycle button pulses into start/stop/lap/clear control.
- Generates the counter's increment enable from a prescaled tick and its synchronous clear.
- Detects terminal count 99 and drives a lap-frozen display copy of the count.

Parameters:
- TICK_DIV, 50, clk cycles per count increment; must be >= 2.
- WRAP, 0, 1 = 99 wraps to 00 and keeps running; 0 = stop at 99 (DONE).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- btn_ss  in  1  start/stop command, single-cycle pulse (already debounced)
- btn_lr  in  1  lap/reset command, single-cycle pulse
- cnt1  in  4  counter tens digit (BCD)
- cnt0  in  4  counter ones digit (BCD)
- cnt_en  out  1  one-cycle increment enable to counter
- cnt_clr  out  1  one-cycle synchronous clear to counter
- disp1  out  4  displayed tens digit
- disp0  out  4  displayed ones digit
- running  out  1  high in RUN or LAP
- done  out  1  high in DONE
- state  out  3  current FSM state encoding (debug)

Behaviour:
- Reset (async, active-high): state=IDLE; prescaler=0; cnt_en=0; cnt_clr=0; disp1=disp0=0; running=0; done=0; lap registers=0.
- States and encoding: IDLE=0, RUN=1, PAUSE=2, LAP=3, DONE=4.
- Prescaler counts 0..TICK_DIV-1 only in RUN/LAP and holds in PAUSE.
- Prescaler clears to 0 on IDLE->RUN.
- tick = (prescaler == TICK_DIV-1) while in RUN/LAP.
- cnt_en is registered: high for exactly the one cycle after the edge where tick is true. Counter increments on the edge where cnt_en is high.
- Terminal count: if tick and {cnt1,cnt0}==8'h99:
  - WRAP=0: no cnt_en; next state DONE.
  - WRAP=1: cnt_en asserted normally (counter wraps to 00); state unchanged.
- Transitions (evaluated each edge; btn_ss has priority, and btn_lr is dropped when both are high):
  - IDLE: btn_ss -> RUN; btn_lr -> IDLE plus cnt_clr pulse.
  - RUN: btn_ss -> PAUSE; btn_lr -> LAP, capturing {cnt1,cnt0} into lap registers on the same edge.
  - LAP: btn_ss -> PAUSE, display returns live; btn_lr -> RUN, display returns live. The counter keeps running in LAP.
  - PAUSE: btn_ss -> RUN with prescaler resumed, not cleared; btn_lr -> IDLE plus cnt_clr pulse.
  - DONE: btn_ss ignored; btn_lr -> IDLE plus cnt_clr pulse.
- cnt_clr: registered, one cycle wide, asserted the cycle after the accepting edge; never asserted together with cnt_en.
- Display: registered, one-cycle latency.
  - LAP: disp = lap registers.
  - All other states: disp = {cnt1,cnt0} delayed one cycle.
- A tick coinciding with a btn_ss exit from RUN/LAP is honoured: cnt_en still pulses, then the prescaler freezes.
- Non-BCD input nibbles (>9) are passed to the display unchanged and never match terminal count.
- Reset asserted mid-run forces all outputs to reset values immediately. The counter is not cleared by this block; a cnt_clr requires a btn_lr from IDLE.

Decomposition:
- Shared package stopwatch_pkg:
  - state encodings (ST_IDLE..ST_DONE, 3 bits)
  - BCD_MAX_TENS=9, BCD_MAX_ONES=9
  - DIGIT_W=4
- One sub-module, stopwatch_tick_gen: prescaler with inputs clk, reset, run, restart and output tick, parameterised by TICK_DIV.
- The FSM, lap registers and output registers stay in stopwatch_ctrl.

Test Plan:
- TICK_DIV=4, reset for 2 cycles then btn_ss pulse -> running=1; cnt_en pulses every 4 cycles; counter reaches 05 after 20 cycles; disp tracks count with 1-cycle lag.
- RUN at count 12, btn_lr pulse -> state=LAP; disp holds 12 while counter advances to 15. Second btn_lr -> disp shows live 15/16.
- RUN, btn_ss at prescaler=2 -> PAUSE with no cnt_en. btn_ss again -> first cnt_en arrives 1 tick-cycle later (prescaler resumed from 2).
- WRAP=0, counter preloaded near 98 -> after 99, the next tick gives done=1, state=DONE, no cnt_en, count stays 99. btn_ss ignored. btn_lr -> cnt_clr one cycle, state=IDLE, count 00.
- WRAP=1 at 99 -> cnt_en asserted, count 00, state stays RUN, done=0.
- btn_ss and btn_lr high in the same cycle in RUN -> PAUSE only, no lap capture. Assert reset mid-LAP -> all outputs 0 asynchronously, state=IDLE.
